// File: rtl/uart_tx_periph.sv
// rtl/uart_tx_periph.sv - memory-mapped transmit-only 8N1 UART with TX FIFO and level interrupt
module uart_tx_periph #(
  parameter int AW          = 16,
  parameter int DW          = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int DEFAULT_DIV = 867
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            uart_req,
  input  logic            uart_write,
  input  logic [DW/8-1:0] uart_wstrb,
  input  logic [AW-1:0]   uart_addr,
  input  logic [DW-1:0]   uart_wdata,
  output logic            uart_ready,
  output logic            uart_rvalid,
  output logic [DW-1:0]   uart_rdata,
  output logic            uart_txd,
  output logic            uart_irq
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

  // Bus decode; only addr[3:2] select a register.
  logic [1:0] reg_sel;
  logic       wr_en;
  logic       rd_en;
  assign reg_sel    = uart_addr[3:2];
  assign wr_en      = uart_req & uart_write;
  assign rd_en      = uart_req & ~uart_write;
  assign uart_ready = 1'b1;

  logic unused_bits;
  assign unused_bits = ^{uart_addr[AW-1:4], uart_addr[1:0], uart_wdata[DW-1:16], uart_wstrb[DW/8-1:2]};

  // Control/status registers
  logic [15:0] div;
  logic        tx_en;
  logic        irq_en;
  logic        ovf;

  // FIFO storage and bookkeeping
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push_req;
  logic          push;
  logic          pop;

  // Full/empty come from the registered count, so a push while full is
  // dropped even if the transmitter pops in the same cycle.
  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign push_req = wr_en & (reg_sel == 2'd0) & uart_wstrb[0];
  assign push     = push_req & ~full;

  // Transmitter state
  state_t      state, state_next;
  logic [15:0] bit_cnt, bit_cnt_next;
  logic [2:0]  bit_idx, bit_idx_next;
  logic [7:0]  shift, shift_next;
  logic        txd_next;
  logic        busy;

  assign busy = (state != ST_IDLE);

  // FIFO payload write; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= uart_wdata[7:0];
  end

  // FIFO pointers and occupancy count
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Register writes and the sticky overflow flag (a new overflow wins over a clear)
  always_ff @(posedge clk) begin
    if (rst) begin
      div    <= 16'(DEFAULT_DIV);
      tx_en  <= 1'b1;
      irq_en <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (push_req && full) begin
        ovf <= 1'b1;
      end else if (wr_en && reg_sel == 2'd1 && uart_wstrb[0] && uart_wdata[3]) begin
        ovf <= 1'b0;
      end
      if (wr_en && reg_sel == 2'd2) begin
        if (uart_wstrb[0]) div[7:0]  <= uart_wdata[7:0];
        if (uart_wstrb[1]) div[15:8] <= uart_wdata[15:8];
      end
      if (wr_en && reg_sel == 2'd3 && uart_wstrb[0]) begin
        tx_en  <= uart_wdata[0];
        irq_en <= uart_wdata[1];
      end
    end
  end

  // Read data mux; the count field saturates at 15 for deep FIFOs.
  logic [3:0]    count_disp;
  logic [DW-1:0] rd_mux;
  always_comb begin
    count_disp = 4'(count);
    if (32'(count) > 32'd15) count_disp = 4'hF;
    rd_mux = '0;
    case (reg_sel)
      2'd1:    rd_mux = DW'({count_disp, ovf, empty, full, busy});
      2'd2:    rd_mux = DW'(div);
      2'd3:    rd_mux = DW'({irq_en, tx_en});
      default: rd_mux = '0;
    endcase
  end

  // Read response one cycle after the request; rdata is zero otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      uart_rvalid <= 1'b0;
      uart_rdata  <= '0;
    end else begin
      uart_rvalid <= rd_en;
      uart_rdata  <= rd_en ? rd_mux : '0;
    end
  end

  // Transmitter next-state: bit_cnt counts down div..0 per bit, reloaded
  // from div at every bit boundary so a new divisor applies to the next bit.
  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    bit_idx_next = bit_idx;
    shift_next   = shift;
    txd_next     = uart_txd;
    pop          = 1'b0;
    case (state)
      ST_IDLE: begin
        txd_next = 1'b1;
        if (tx_en && !empty) begin
          pop          = 1'b1;
          shift_next   = mem[rd_ptr];
          bit_cnt_next = div;
          txd_next     = 1'b0;
          state_next   = ST_START;
        end
      end
      ST_START: begin
        if (bit_cnt == '0) begin
          bit_cnt_next = div;
          bit_idx_next = '0;
          txd_next     = shift[0];
          state_next   = ST_DATA;
        end else begin
          bit_cnt_next = bit_cnt - 16'd1;
        end
      end
      ST_DATA: begin
        if (bit_cnt == '0) begin
          bit_cnt_next = div;
          if (bit_idx == 3'd7) begin
            txd_next   = 1'b1;
            state_next = ST_STOP;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
            shift_next   = {1'b0, shift[7:1]};
            txd_next     = shift[1];
          end
        end else begin
          bit_cnt_next = bit_cnt - 16'd1;
        end
      end
      ST_STOP: begin
        if (bit_cnt == '0) begin
          state_next = ST_IDLE;
        end else begin
          bit_cnt_next = bit_cnt - 16'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Transmitter state register; reset abandons any partial frame with txd high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      uart_txd <= 1'b1;
    end else begin
      state    <= state_next;
      bit_cnt  <= bit_cnt_next;
      bit_idx  <= bit_idx_next;
      shift    <= shift_next;
      uart_txd <= txd_next;
    end
  end

  // Level interrupt: transmitter fully drained and idle.
  always_ff @(posedge clk) begin
    if (rst) uart_irq <= 1'b0;
    else     uart_irq <= irq_en & empty & ~busy;
  end

endmodule

// File: tb/tb_uart_tx_periph.sv
// tb/tb_uart_tx_periph.sv - scoreboard bench for uart_tx_periph
module tb_uart_tx_periph;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        write;
  logic [3:0]  wstrb;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;
  logic        txd;
  logic        irq;

  uart_tx_periph dut (
    .clk(clk), .rst(rst),
    .uart_req(req), .uart_write(write), .uart_wstrb(wstrb), .uart_addr(addr), .uart_wdata(wdata),
    .uart_ready(ready), .uart_rvalid(rvalid), .uart_rdata(rdata),
    .uart_txd(txd), .uart_irq(irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0]        data;
    logic [9:0][15:0]  len;
  } frame_t;

  typedef struct packed {
    logic [31:0] val;
    logic [31:0] cyc;
  } rd_t;

  frame_t exp_frames[$];
  rd_t    exp_rd[$];

  int tests = 0;
  int fails = 0;

  // reference model of the programmer-visible state
  logic [15:0] m_div;
  logic        m_txen, m_irq_en, m_ovf;
  int          m_count;

  logic mon_en = 1'b1;
  logic in_frame = 1'b0;
  int   mon_start = 0;
  int   mon_end = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] stat(input int busy, input int cnt, input int ov);
    int c;
    c = (cnt > 15) ? 15 : cnt;
    return 32'(busy + 2 * int'(cnt == DEPTH) + 4 * int'(cnt == 0) + 8 * ov + 16 * c);
  endfunction

  task automatic model_reset();
    m_div = 16'd867; m_txen = 1'b1; m_irq_en = 1'b0; m_ovf = 1'b0; m_count = 0;
  endtask

  task automatic tx_accept(input logic [7:0] b);
    frame_t f;
    if (!m_txen && m_count == DEPTH) begin
      m_ovf = 1'b1;
    end else begin
      f.data = b;
      for (int i = 0; i < 10; i++) f.len[i] = m_div + 16'd1;
      exp_frames.push_back(f);
      if (!m_txen) m_count++;
    end
  endtask

  task automatic bus_write(input int r, input logic [31:0] d, input logic [3:0] s);
    logic [15:0] rnd;
    rnd = 16'($urandom);
    addr = {rnd[15:4], 2'(r), rnd[1:0]};
    req = 1'b1; write = 1'b1; wdata = d; wstrb = s;
    case (r)
      0: if (s[0]) tx_accept(d[7:0]);
      1: if (s[0] && d[3]) m_ovf = 1'b0;
      2: begin
        if (s[0]) m_div[7:0] = d[7:0];
        if (s[1]) m_div[15:8] = d[15:8];
      end
      default: if (s[0]) begin m_txen = d[0]; m_irq_en = d[1]; m_count = 0; end
    endcase
    @(negedge clk);
    req = 1'b0; write = 1'b0; wstrb = '0;
  endtask

  task automatic bus_read(input int r, input logic [31:0] e);
    rd_t x;
    logic [15:0] rnd;
    rnd = 16'($urandom);
    x.val = e; x.cyc = 32'(cyc);
    exp_rd.push_back(x);
    addr = {rnd[15:4], 2'(r), rnd[1:0]};
    req = 1'b1; write = 1'b0; wstrb = 4'($urandom);
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_frames.size() != 0 || in_frame) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(n < 5000), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  // read-response monitor
  initial begin
    rd_t e;
    forever begin
      @(negedge clk);
      if (rvalid === 1'b1) begin
        if (exp_rd.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_rvalid: got rvalid=1 rdata=%0h required rvalid=0", rdata);
        end else begin
          e = exp_rd.pop_front();
          check("rdata", rdata, e.val);
          check("rd_latency", 32'(cyc), e.cyc + 32'd1);
        end
      end
    end
  end

  // serial frame monitor: slot 0 is the start bit, 1..8 data LSB first, 9 stop
  initial begin
    frame_t f;
    logic   lvl;
    logic   ok;
    int     bad_slot, bad_cyc;
    logic   bad_got;
    forever begin
      @(negedge clk);
      if (mon_en && txd === 1'b0) begin
        if (exp_frames.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_frame: got start bit at cycle %0d required idle line", cyc);
          for (int n = 0; n < 400 && txd !== 1'b1; n++) @(negedge clk);
        end else begin
          in_frame = 1'b1;
          mon_start = cyc;
          f = exp_frames.pop_front();
          ok = 1'b1; bad_slot = 0; bad_cyc = 0; bad_got = 1'b0;
          for (int seg = 0; seg < 10; seg++) begin
            lvl = (seg == 0) ? 1'b0 : (seg == 9) ? 1'b1 : f.data[seg-1];
            for (int k = 0; k < int'(f.len[seg]); k++) begin
              if (!(seg == 0 && k == 0)) @(negedge clk);
              if (txd !== lvl && ok) begin
                ok = 1'b0; bad_slot = seg; bad_cyc = cyc; bad_got = txd;
              end
            end
          end
          mon_end = cyc;
          tests++;
          if (!ok) begin
            fails++;
            $display("FAIL frame %02h: slot %0d cycle %0d got txd=%b required %b", f.data, bad_slot, bad_cyc, bad_got, ~bad_got);
          end
          in_frame = 1'b0;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0, fi, lows;
    frame_t f;
    rst = 1'b1; req = 1'b0; write = 1'b0; wstrb = '0; addr = '0; wdata = '0;
    model_reset();
    repeat (3) @(negedge clk);

    // reset state
    check("reset_txd", 32'(txd), 32'd1);
    check("reset_irq", 32'(irq), 32'd0);
    check("reset_rvalid", 32'(rvalid), 32'd0);
    check("reset_rdata", rdata, 32'd0);
    rst = 1'b0;
    bus_read(1, stat(0, 0, 0));
    bus_read(2, 32'd867);
    bus_read(3, 32'd1);
    bus_read(0, 32'd0);
    repeat (2) @(negedge clk);

    // 0x55 at div=3: latency and timing
    bus_write(2, 32'd3, 4'b0011);
    n0 = cyc;
    bus_write(0, 32'h55, 4'b0001);
    wait_cyc(n0 + 10);
    bus_read(1, stat(1, 0, 0));
    wait_drain();
    check("start_latency", 32'(mon_start), 32'(n0 + 2));

    // divisor 3 -> 7 written during data bit 2 of 0xFF
    n0 = cyc;
    bus_write(0, 32'hFF, 4'b0001);
    f = exp_frames.pop_back();
    for (int i = 4; i < 10; i++) f.len[i] = 16'd8;
    exp_frames.push_back(f);
    wait_cyc(n0 + 15);
    bus_write(2, 32'd7, 4'b0011);
    wait_drain();
    check("div_change_latency", 32'(mon_start), 32'(n0 + 2));

    // overflow with transmitter disabled, then drain at div=0
    bus_write(2, 32'd0, 4'b0011);
    bus_write(3, 32'd0, 4'b0001);
    for (int i = 0; i < DEPTH; i++) bus_write(0, $urandom, 4'b0001);
    bus_read(1, stat(0, 8, 0));
    bus_write(0, $urandom, 4'b0001);
    bus_read(1, stat(0, 8, 1));
    bus_write(1, 32'h0, 4'b0001);
    bus_read(1, stat(0, 8, 1));
    bus_write(1, 32'h8, 4'b0001);
    bus_read(1, stat(0, 8, 0));
    bus_write(3, 32'd1, 4'b0001);
    wait_drain();
    bus_read(1, stat(0, 0, 0));

    // interrupt behaviour at div=1
    bus_write(2, 32'd1, 4'b0011);
    bus_write(3, 32'd3, 4'b0001);
    @(negedge clk);
    check("irq_idle", 32'(irq), 32'd1);
    bus_write(0, $urandom, 4'b0001);
    check("irq_hold", 32'(irq), 32'd1);
    bus_write(0, $urandom, 4'b0001);
    check("irq_drop", 32'(irq), 32'd0);
    fi = -1;
    for (int n = 0; n < 500 && fi < 0; n++) begin
      @(negedge clk);
      if (irq === 1'b1) fi = cyc;
    end
    wait_drain();
    check("irq_rise", 32'(fi), 32'(mon_end + 2));
    bus_write(0, $urandom, 4'b0001);
    check("irq_push_hold", 32'(irq), 32'd1);
    @(negedge clk);
    check("irq_push_drop", 32'(irq), 32'd0);
    wait_drain();
    bus_write(3, 32'd1, 4'b0001);

    // randomized batches
    for (int b = 0; b < 6; b++) begin
      bus_write(2, 32'($urandom_range(0, 3)), 4'b0011);
      bus_write(3, {30'd0, 1'($urandom), 1'b1}, 4'b0001);
      for (int i = 0; i < int'($urandom_range(1, 8)); i++) begin
        bus_write(0, $urandom, {3'($urandom), 1'(($urandom % 5) != 0)});
        repeat ($urandom % 3) @(negedge clk);
      end
      bus_read(0, 32'd0);
      bus_read(3, {30'd0, m_irq_en, m_txen});
      bus_read(2, 32'(m_div));
      wait_drain();
      bus_read(1, stat(0, 0, 0));
      bus_write(2, $urandom, 4'($urandom));
      bus_read(2, 32'(m_div));
    end

    // reset in the middle of the data bits of 0xA3
    bus_write(2, 32'd3, 4'b0011);
    bus_write(3, 32'd1, 4'b0001);
    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    n0 = cyc;
    bus_write(0, 32'hA3, 4'b0001);
    f = exp_frames.pop_back();
    wait_cyc(n0 + 10);
    check("pre_reset_busy_line", 32'(txd), 32'(f.data[1]));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("reset_mid_txd", 32'(txd), 32'd1);
    bus_read(1, stat(0, 0, 0));
    lows = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    check("no_residual_frame", 32'(lows), 32'd0);
    bus_read(2, 32'd867);
    repeat (3) @(negedge clk);
    mon_en = 1'b1;

    check("frames_left", 32'(exp_frames.size()), 32'd0);
    check("reads_left", 32'(exp_rd.size()), 32'd0);
    check("ready_tied", 32'(ready), 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
